// File: rtl/mm_loader.sv
// -----------------------------------------------------------------------------
// mm_loader
//
// Sequencer that feeds a matrix-multiply array. On an accepted start it:
//   1. streams K activation words from activation memory into the row FIFOs,
//   2. idles one cycle while the first weight word is fetched,
//   3. serialises K weight words into the column FIFOs, one bit per column
//      per cycle, LSB first, `precision` bits per word,
//   4. waits two cycles, runs the array for K*precision cycles,
//   5. pulses done and returns to IDLE.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           one-cycle request (IDLE only)
//   precision       weight bit count, latched on accepted start
//   act_rd_addr     activation memory address (sync read, 1-cycle latency)
//   act_rd_data     activation memory data
//   w_rd_addr       weight memory address (sync read, 1-cycle latency)
//   w_rd_data       weight memory data, W_BITS per column
//   act_din         row activations to the activation FIFOs
//   wr_en_act       activation FIFO write strobe
//   w_din           one serial weight bit per column FIFO
//   wr_en_w         weight FIFO write strobe
//   fifo_full       OR of all FIFO full flags
//   active          compute enable for the array
//   busy            high in every state except IDLE
//   done            one-cycle end-of-sequence pulse
//   err             sticky: bad precision on start, or write while full
// -----------------------------------------------------------------------------
module mm_loader #(
    parameter int ACT_WIDTH = 16,
    parameter int N         = 2,
    parameter int K         = 2,
    parameter int W_BITS    = 8,
    localparam int AW       = (K > 1) ? $clog2(K) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3:0]             precision,
    output logic [AW-1:0]          act_rd_addr,
    input  logic [N*ACT_WIDTH-1:0] act_rd_data,
    output logic [AW-1:0]          w_rd_addr,
    input  logic [N*W_BITS-1:0]    w_rd_data,
    output logic [N*ACT_WIDTH-1:0] act_din,
    output logic                   wr_en_act,
    output logic [N-1:0]           w_din,
    output logic                   wr_en_w,
    input  logic                   fifo_full,
    output logic                   active,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    // Counter range covers K*W_BITS strobes; also covers K+1 ACT cycles.
    localparam int CW = $clog2(K * W_BITS + 1);
    localparam int BW = (W_BITS > 1) ? $clog2(W_BITS) : 1;

    typedef enum logic [2:0] {IDLE, ACT, GAP, WLOAD, WAIT, RUN, DONE} state_t;

    state_t        state_reg;
    logic [3:0]    prec_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] bit_reg;
    logic [CW-1:0] word_reg;

    logic [CW-1:0] prec_ext;
    logic [CW-1:0] total;
    logic [CW-1:0] last_bit;
    logic [CW-1:0] bit_next;
    logic [CW-1:0] word_next;
    logic          prec_ok;

    always_comb begin
        prec_ext  = CW'(prec_reg);
        total     = CW'(K) * prec_ext;
        last_bit  = prec_ext - 1'b1;
        bit_next  = bit_reg + 1'b1;
        word_next = word_reg;
        if (bit_reg == last_bit) begin
            bit_next  = '0;
            word_next = word_reg + 1'b1;
        end
        prec_ok = (precision != 4'd0) && (int'(precision) <= W_BITS);
    end

    // Activation data goes straight through: the address was issued the
    // cycle before, so the read data lines up with the strobe.
    assign act_din = act_rd_data;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_wbit
            logic [W_BITS-1:0] col_word;
            assign col_word  = w_rd_data[gi*W_BITS +: W_BITS];
            assign w_din[gi] = col_word[bit_reg[BW-1:0]];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            prec_reg    <= '0;
            cnt_reg     <= '0;
            bit_reg     <= '0;
            word_reg    <= '0;
            act_rd_addr <= '0;
            w_rd_addr   <= '0;
            wr_en_act   <= 1'b0;
            wr_en_w     <= 1'b0;
            active      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            // Overflow flags an error but never stalls the sequence.
            if ((wr_en_act || wr_en_w) && fifo_full) begin
                err <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (prec_ok) begin
                            state_reg   <= ACT;
                            prec_reg    <= precision;
                            cnt_reg     <= '0;
                            act_rd_addr <= '0;
                            busy        <= 1'b1;
                            err         <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                // K+1 cycles: addresses go out in the first K, strobes
                // follow one cycle behind in the last K.
                ACT: begin
                    if (cnt_reg == CW'(K)) begin
                        state_reg <= GAP;
                        wr_en_act <= 1'b0;
                        w_rd_addr <= '0;
                    end else begin
                        cnt_reg   <= cnt_reg + 1'b1;
                        wr_en_act <= 1'b1;
                        if (cnt_reg + 1'b1 < CW'(K)) begin
                            act_rd_addr <= AW'(cnt_reg + 1'b1);
                        end
                    end
                end

                GAP: begin
                    state_reg <= WLOAD;
                    wr_en_w   <= 1'b1;
                    cnt_reg   <= '0;
                    bit_reg   <= '0;
                    word_reg  <= '0;
                    // With one-bit precision the first strobe is already the
                    // last bit of word 0, so word 1 must be requested now.
                    w_rd_addr <= ((last_bit == '0) && (K > 1)) ? AW'(1) : '0;
                end

                // The next word's address goes out during the last bit of
                // the current word, so its data is valid on the next strobe.
                WLOAD: begin
                    if (cnt_reg == total - 1'b1) begin
                        state_reg <= WAIT;
                        wr_en_w   <= 1'b0;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg  <= cnt_reg + 1'b1;
                        bit_reg  <= bit_next;
                        word_reg <= word_next;
                        if ((bit_next == last_bit) && (word_next + 1'b1 < CW'(K))) begin
                            w_rd_addr <= AW'(word_next + 1'b1);
                        end
                    end
                end

                WAIT: begin
                    if (cnt_reg == CW'(1)) begin
                        state_reg <= RUN;
                        active    <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                RUN: begin
                    if (cnt_reg == total - 1'b1) begin
                        state_reg <= DONE;
                        active    <= 1'b0;
                        done      <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                DONE: begin
                    state_reg <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_loader.sv
// -----------------------------------------------------------------------------
// tb_mm_loader
//
// Directed sequence of load/run transactions against mm_loader with default
// parameters. Memory contents and most precisions are random. Expected
// per-cycle outputs come from the sequence timeline (offsets from the cycle
// in which start is presented) and from the memory arrays.
// -----------------------------------------------------------------------------
module tb_mm_loader;

    localparam int ACT_WIDTH = 16;
    localparam int N         = 2;
    localparam int K         = 2;
    localparam int W_BITS    = 8;
    localparam int AW        = (K > 1) ? $clog2(K) : 1;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic [3:0]             precision;
    logic [AW-1:0]          act_rd_addr;
    logic [N*ACT_WIDTH-1:0] act_rd_data;
    logic [AW-1:0]          w_rd_addr;
    logic [N*W_BITS-1:0]    w_rd_data;
    logic [N*ACT_WIDTH-1:0] act_din;
    logic                   wr_en_act;
    logic [N-1:0]           w_din;
    logic                   wr_en_w;
    logic                   fifo_full;
    logic                   active;
    logic                   busy;
    logic                   done;
    logic                   err;

    logic [N*ACT_WIDTH-1:0] act_mem [K];
    logic [N*W_BITS-1:0]    w_mem   [K];

    int checks = 0;
    int errors = 0;
    int run_len;
    int p_rand;

    mm_loader #(
        .ACT_WIDTH(ACT_WIDTH), .N(N), .K(K), .W_BITS(W_BITS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .precision(precision),
        .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
        .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
        .act_din(act_din), .wr_en_act(wr_en_act),
        .w_din(w_din), .wr_en_w(wr_en_w), .fifo_full(fifo_full),
        .active(active), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories.
    always @(posedge clk) begin
        act_rd_data <= act_mem[act_rd_addr];
        w_rd_data   <= w_mem[w_rd_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_mem();
        for (int k = 0; k < K; k++) begin
            act_mem[k] = (N*ACT_WIDTH)'({$urandom(), $urandom()});
            w_mem[k]   = (N*W_BITS)'($urandom());
        end
    endtask

    // One (or, with hold, two back-to-back) sequences. t counts cycles from
    // the cycle in which start is presented; tt is t within the sequence.
    task automatic run_seq(input int p, input bit full_mode, input bit hold, input bit err_in);
        int wl, w0, r0, d, per, nseq, tt, j;
        logic [N*W_BITS-1:0] wv;
        logic [N-1:0]        wexp;
        wl   = K * p;
        w0   = K + 3;
        r0   = w0 + wl + 2;
        d    = r0 + wl;
        per  = d + 1;
        nseq = hold ? 2 : 1;
        $display("run: precision=%0d fifo_full_mode=%0d hold=%0d", p, full_mode, hold);
        @(negedge clk);
        for (int t = 0; t <= nseq * per; t++) begin
            if (t > 0) @(negedge clk);
            tt = t % per;
            chk("busy", busy, (tt >= 1) && (tt <= d));
            chk("wr_en_act", wr_en_act, (tt >= 2) && (tt < 2 + K));
            if ((tt >= 2) && (tt < 2 + K)) chk("act_din", act_din, act_mem[tt-2]);
            chk("wr_en_w", wr_en_w, (tt >= w0) && (tt < w0 + wl));
            if ((tt >= w0) && (tt < w0 + wl)) begin
                j  = tt - w0;
                wv = w_mem[j / p];
                for (int c = 0; c < N; c++) wexp[c] = wv[c*W_BITS + (j % p)];
                chk("w_din", w_din, wexp);
            end
            chk("active", active, (tt >= r0) && (tt < d));
            chk("done", done, tt == d);
            chk("err", err, (t == 0) ? err_in : (full_mode && ((tt == 0) || (tt >= w0 + 1))));
            start     = hold ? (t < nseq * per) : (t == 0);
            precision = 4'(p);
            fifo_full = full_mode && (tt >= w0) && (tt < w0 + wl);
        end
        start     = 1'b0;
        fifo_full = 1'b0;
    endtask

    task automatic bad_prec(input int p);
        $display("bad start: precision=%0d", p);
        @(negedge clk);
        start     = 1'b1;
        precision = 4'(p);
        @(negedge clk);
        start = 1'b0;
        chk("bad_err", err, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("bad_busy", busy, 1'b0);
            chk("bad_strobes", {wr_en_act, wr_en_w, active, done}, 4'b0000);
            @(negedge clk);
        end
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        precision = 4'd0;
        fifo_full = 1'b0;
        fill_mem();
        repeat (2) @(negedge clk);

        $display("reset state");
        chk("rst_outputs", {busy, done, active, wr_en_act, wr_en_w, err}, 6'b000000);
        chk("rst_act_addr", act_rd_addr, '0);
        chk("rst_w_addr", w_rd_addr, '0);
        rst = 1'b1;

        // Known weight word 0: col1=0x03, col0=0x0A.
        w_mem[0] = 16'h030A;
        run_seq(4, 1'b0, 1'b0, 1'b0);

        bad_prec(0);
        bad_prec(9);
        run_seq(4, 1'b0, 1'b0, 1'b1);

        fill_mem();
        run_seq(1, 1'b0, 1'b0, 1'b0);
        fill_mem();
        run_seq(8, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            fill_mem();
            p_rand = int'($urandom_range(1, 8));
            run_seq(p_rand, 1'b0, 1'b0, 1'b0);
        end

        fill_mem();
        run_seq(4, 1'b1, 1'b0, 1'b0);
        fill_mem();
        run_seq(int'($urandom_range(1, 8)), 1'b0, 1'b0, 1'b1);

        fill_mem();
        run_seq(3, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of RUN.
        $display("reset during RUN");
        run_len = (K + 3) + K * 4 + 2 + 2;
        @(negedge clk);
        start     = 1'b1;
        precision = 4'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (run_len - 1) @(negedge clk);
        chk("active_pre_rst", active, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("active_async_rst", active, 1'b0);
        chk("busy_async_rst", busy, 1'b0);
        repeat (2) @(negedge clk);
        chk("in_rst_outputs", {busy, done, active, wr_en_act, wr_en_w}, 5'b00000);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", {busy, done, active, wr_en_act, wr_en_w}, 5'b00000);
        fill_mem();
        run_seq(4, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
